// File: rtl/decode_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_pkg: RV32 decode constants, field encodings and ctrl_t.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package decode_pkg;

    localparam logic [6:0] c_opc_load    = 7'b0000011;
    localparam logic [6:0] c_opc_misc    = 7'b0001111;
    localparam logic [6:0] c_opc_op_imm  = 7'b0010011;
    localparam logic [6:0] c_opc_auipc   = 7'b0010111;
    localparam logic [6:0] c_opc_store   = 7'b0100011;
    localparam logic [6:0] c_opc_op      = 7'b0110011;
    localparam logic [6:0] c_opc_lui     = 7'b0110111;
    localparam logic [6:0] c_opc_branch  = 7'b1100011;
    localparam logic [6:0] c_opc_jalr    = 7'b1100111;
    localparam logic [6:0] c_opc_jal     = 7'b1101111;
    localparam logic [6:0] c_opc_system  = 7'b1110011;

    localparam logic [6:0] c_f7_base     = 7'b0000000;
    localparam logic [6:0] c_f7_alt      = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv   = 7'b0000001;

    localparam logic [2:0] c_f3_beq      = 3'b000;
    localparam logic [2:0] c_f3_bne      = 3'b001;
    localparam logic [2:0] c_f3_blt      = 3'b100;
    localparam logic [2:0] c_f3_bge      = 3'b101;
    localparam logic [2:0] c_f3_bltu     = 3'b110;
    localparam logic [2:0] c_f3_bgeu     = 3'b111;

    localparam logic [2:0] c_alu_add     = 3'b000;
    localparam logic [2:0] c_alu_sub     = 3'b001;
    localparam logic [2:0] c_alu_slt     = 3'b010;
    localparam logic [2:0] c_alu_sltu    = 3'b011;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_J = 3'b100,
        IMM_B = 3'b101
    } imm_sel_e;

    typedef enum logic [1:0] {
        REGD_MEM  = 2'b00,
        REGD_EXEC = 2'b01,
        REGD_IMM  = 2'b10,
        REGD_PC4  = 2'b11
    } regd_sel_e;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       src_a_sel;
        logic       src_b_sel;
        logic       alu_set;
        logic [2:0] alu_op;
        logic       exec_sel;
        logic       mem_write;
        logic       mem_en;
        logic       reg_write;
        logic [1:0] regd_sel;
        logic       jump;
        logic       branch;
        logic       branch_neg;
        logic       recode;
        logic       system;
        logic       csr;
        logic       muldiv;
        logic [2:0] muldiv_op;
        logic       illegal;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_stage_if: upstream/downstream handshake of the decode stage.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    ctrl_t           out_ctrl;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_instr, out_pc
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_instr, out_pc
    );
endinterface
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_logic: combinational RV32I/M/Zicsr instruction -> ctrl_t.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module decode_logic
    import decode_pkg::*;
#(
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_f7_std;
    logic       w_shift;
    logic       w_illegal;
    ctrl_t      w_ctrl;
    logic       w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_f7_std = (w_funct7 == c_f7_base) || (w_funct7 == c_f7_alt);
    assign w_shift  = (w_funct3[1:0] == 2'b01);
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_opc_op_imm: begin
                w_ctrl.imm_sel   = IMM_I;
                w_ctrl.src_a_sel = 1'b1;
                w_ctrl.src_b_sel = 1'b1;
                w_ctrl.exec_sel  = w_shift;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.regd_sel  = REGD_EXEC;
                w_illegal        = w_shift && !w_f7_std;
            end
            c_opc_op: begin
                if (w_f7_std) begin
                    w_ctrl.src_a_sel = 1'b1;
                    w_ctrl.exec_sel  = w_shift;
                    w_ctrl.recode    = 1'b1;
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.regd_sel  = REGD_EXEC;
                    // Only SUB and SRA use the alternate funct7
                    w_illegal = (w_funct7 == c_f7_alt) &&
                                (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                end else if ((w_funct7 == c_f7_muldiv) && ENABLE_M) begin
                    w_ctrl.muldiv    = 1'b1;
                    w_ctrl.muldiv_op = w_funct3;
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.regd_sel  = REGD_EXEC;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_opc_lui: begin
                w_ctrl.imm_sel   = IMM_U;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.regd_sel  = REGD_IMM;
            end
            c_opc_auipc: begin
                w_ctrl.imm_sel   = IMM_U;
                w_ctrl.src_b_sel = 1'b1;
                w_ctrl.alu_set   = 1'b1;
                w_ctrl.alu_op    = c_alu_add;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.regd_sel  = REGD_EXEC;
            end
            c_opc_load: begin
                w_ctrl.imm_sel   = IMM_I;
                w_ctrl.alu_set   = 1'b1;
                w_ctrl.alu_op    = c_alu_add;
                w_ctrl.mem_en    = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.regd_sel  = REGD_MEM;
                w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                            (w_funct3 == 3'b111);
            end
            c_opc_store: begin
                w_ctrl.imm_sel   = IMM_S;
                w_ctrl.alu_set   = 1'b1;
                w_ctrl.alu_op    = c_alu_add;
                w_ctrl.mem_en    = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_illegal        = (w_funct3 > 3'b010);
            end
            c_opc_jal: begin
                w_ctrl.imm_sel   = IMM_J;
                w_ctrl.src_b_sel = 1'b1;
                w_ctrl.alu_set   = 1'b1;
                w_ctrl.alu_op    = c_alu_add;
                w_ctrl.jump      = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.regd_sel  = REGD_PC4;
            end
            c_opc_jalr: begin
                w_ctrl.imm_sel   = IMM_I;
                w_ctrl.src_a_sel = 1'b1;
                w_ctrl.src_b_sel = 1'b1;
                w_ctrl.alu_set   = 1'b1;
                w_ctrl.alu_op    = c_alu_add;
                w_ctrl.jump      = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.regd_sel  = REGD_PC4;
                w_illegal        = (w_funct3 != 3'b000);
            end
            c_opc_branch: begin
                w_ctrl.imm_sel   = IMM_B;
                w_ctrl.src_a_sel = 1'b1;
                w_ctrl.branch    = 1'b1;
                w_ctrl.alu_set   = 1'b1;
                case (w_funct3)
                    c_f3_beq:  w_ctrl.alu_op = c_alu_sub;
                    c_f3_bne:  begin w_ctrl.alu_op = c_alu_sub;  w_ctrl.branch_neg = 1'b1; end
                    c_f3_blt:  begin w_ctrl.alu_op = c_alu_slt;  w_ctrl.branch_neg = 1'b1; end
                    c_f3_bge:  w_ctrl.alu_op = c_alu_slt;
                    c_f3_bltu: begin w_ctrl.alu_op = c_alu_sltu; w_ctrl.branch_neg = 1'b1; end
                    c_f3_bgeu: w_ctrl.alu_op = c_alu_sltu;
                    default:   w_illegal = 1'b1;
                endcase
            end
            c_opc_misc: begin
                w_ctrl = '0;
            end
            c_opc_system: begin
                w_ctrl.system = 1'b1;
                if (w_funct3 != 3'b000) begin
                    if (ENABLE_ZICSR) begin
                        w_ctrl.csr       = 1'b1;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.regd_sel  = REGD_EXEC;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_illegal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
            w_ctrl.system  = 1'b1;
        end
    end

    assign o_ctrl = w_ctrl;
endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_stage: registered decode with a 2-entry skid buffer.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);
    logic            r_main_valid;
    logic            r_skid_valid;
    ctrl_t           r_main_ctrl;
    ctrl_t           r_skid_ctrl;
    logic [31:0]     r_main_instr;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_skid_pc;
    ctrl_t           w_dec_ctrl;
    logic            w_accept;
    logic            w_xfer;

    decode_logic #(
        .ENABLE_M     (ENABLE_M),
        .ENABLE_ZICSR (ENABLE_ZICSR)
    ) u_decode_logic (
        .i_instr (bus.in_instr),
        .o_ctrl  (w_dec_ctrl)
    );

    // in_ready depends only on skid occupancy, never on out_ready
    assign w_accept = bus.in_valid && !r_skid_valid;
    assign w_xfer   = r_main_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_ctrl  <= '0;
            r_main_instr <= '0;
            r_skid_instr <= '0;
            r_main_pc    <= '0;
            r_skid_pc    <= '0;
        end else if (bus.flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_xfer && r_skid_valid) begin
            r_main_ctrl  <= r_skid_ctrl;
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
        end else if (w_accept && (!r_main_valid || w_xfer)) begin
            r_main_ctrl  <= w_dec_ctrl;
            r_main_instr <= bus.in_instr;
            r_main_pc    <= bus.in_pc;
            r_main_valid <= 1'b1;
        end else if (w_accept) begin
            r_skid_ctrl  <= w_dec_ctrl;
            r_skid_instr <= bus.in_instr;
            r_skid_pc    <= bus.in_pc;
            r_skid_valid <= 1'b1;
        end else if (w_xfer) begin
            r_main_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = !r_skid_valid;
    assign bus.out_valid = r_main_valid;
    assign bus.out_ctrl  = r_main_ctrl;
    assign bus.out_instr = r_main_instr;
    assign bus.out_pc    = r_main_pc;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_decode_stage: random + directed bench with a FIFO/decode model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_decode_stage;
    import decode_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    bit   checking_on;

    decode_stage_if #(.XLEN(32)) bus  ();
    decode_stage_if #(.XLEN(32)) bus0 ();

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_ZICSR(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    assign bus0.flush     = bus.flush;
    assign bus0.in_valid  = bus.in_valid;
    assign bus0.in_instr  = bus.in_instr;
    assign bus0.in_pc     = bus.in_pc;
    assign bus0.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference decode written from the ISA field rules, keyed on opcode[6:2]
    function automatic ctrl_t ref_decode(input logic [31:0] ins, input bit en_m, input bit en_z);
        ctrl_t c;
        bit bad;
        logic [2:0] f3;
        logic [6:0] f7;
        bit f7_std, sh;
        c = '0; bad = 0;
        f3 = ins[14:12]; f7 = ins[31:25];
        f7_std = (f7 == 7'h00) || (f7 == 7'h20);
        sh = (f3 == 3'd1) || (f3 == 3'd5);
        if (ins[1:0] != 2'b11) bad = 1;
        else case (ins[6:2])
            5'h04: begin
                c.src_a_sel = 1; c.src_b_sel = 1; c.exec_sel = sh;
                c.reg_write = 1; c.regd_sel = 2'b01; bad = sh && !f7_std;
            end
            5'h0C: begin
                if (f7_std) begin
                    c.src_a_sel = 1; c.exec_sel = sh; c.recode = 1;
                    c.reg_write = 1; c.regd_sel = 2'b01;
                    bad = (f7 == 7'h20) && !(f3 == 3'd0 || f3 == 3'd5);
                end else if (f7 == 7'h01 && en_m) begin
                    c.muldiv = 1; c.muldiv_op = f3; c.reg_write = 1; c.regd_sel = 2'b01;
                end else bad = 1;
            end
            5'h0D: begin c.imm_sel = 3'b010; c.reg_write = 1; c.regd_sel = 2'b10; end
            5'h05: begin
                c.imm_sel = 3'b010; c.src_b_sel = 1; c.alu_set = 1;
                c.reg_write = 1; c.regd_sel = 2'b01;
            end
            5'h00: begin
                c.alu_set = 1; c.mem_en = 1; c.reg_write = 1;
                bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            5'h08: begin
                c.imm_sel = 3'b001; c.alu_set = 1; c.mem_en = 1; c.mem_write = 1;
                bad = (f3 > 3'd2);
            end
            5'h1B: begin
                c.imm_sel = 3'b100; c.src_b_sel = 1; c.alu_set = 1;
                c.jump = 1; c.reg_write = 1; c.regd_sel = 2'b11;
            end
            5'h19: begin
                c.src_a_sel = 1; c.src_b_sel = 1; c.alu_set = 1;
                c.jump = 1; c.reg_write = 1; c.regd_sel = 2'b11; bad = (f3 != 3'd0);
            end
            5'h18: begin
                c.imm_sel = 3'b101; c.src_a_sel = 1; c.branch = 1; c.alu_set = 1;
                c.alu_op = f3[2] ? {2'b01, f3[1]} : 3'b001;
                c.branch_neg = f3[2] ^ f3[0];
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            5'h03: c = '0;
            5'h1C: begin
                c.system = 1;
                if (f3 != 3'd0) begin
                    if (en_z) begin c.csr = 1; c.reg_write = 1; c.regd_sel = 2'b01; end
                    else bad = 1;
                end
            end
            default: bad = 1;
        endcase
        if (bad) begin c = '0; c.illegal = 1; c.system = 1; end
        return c;
    endfunction

    // Stage modelled as a 2-deep FIFO: ready while not full, valid while not empty
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    ent_t q[$];
    bit   fresh;
    bit   m_acc, m_xfer;

    always @(posedge clk) begin
        m_acc  = bus.in_valid && (q.size() < 2);
        m_xfer = (q.size() > 0) && bus.out_ready;
        if (!rst_n) begin
            q.delete();
            fresh = 1;
        end else if (bus.flush) begin
            q.delete();
        end else begin
            if (m_xfer) void'(q.pop_front());
            if (m_acc) begin
                q.push_back('{instr: bus.in_instr, pc: bus.in_pc});
                fresh = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking_on) begin
            chk("in_ready",  {63'd0, bus.in_ready},   {63'd0, q.size() < 2});
            chk("out_valid", {63'd0, bus.out_valid},  {63'd0, q.size() > 0});
            chk("out_valid_cfg0", {63'd0, bus0.out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                chk("out_instr", {32'd0, bus.out_instr}, {32'd0, q[0].instr});
                chk("out_pc",    {32'd0, bus.out_pc},    {32'd0, q[0].pc});
                chk("out_ctrl",      {38'd0, bus.out_ctrl},  {38'd0, ref_decode(q[0].instr, 1, 1)});
                chk("out_ctrl_cfg0", {38'd0, bus0.out_ctrl}, {38'd0, ref_decode(q[0].instr, 0, 0)});
            end else if (fresh) begin
                chk("reset_ctrl",  {38'd0, bus.out_ctrl}, 64'd0);
                chk("reset_instr", {32'd0, bus.out_instr}, 64'd0);
                chk("reset_pc",    {32'd0, bus.out_pc}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opc;
        ins = $urandom;
        case ($urandom_range(0, 13))
            0, 1:    opc = 7'b0010011;
            2, 3:    opc = 7'b0110011;
            4:       opc = 7'b0110111;
            5:       opc = 7'b0010111;
            6:       opc = 7'b0000011;
            7:       opc = 7'b0100011;
            8:       opc = 7'b1101111;
            9:       opc = 7'b1100111;
            10:      opc = 7'b1100011;
            11:      opc = 7'b0001111;
            12:      opc = 7'b1110011;
            default: opc = ins[6:0];
        endcase
        ins[6:0] = opc;
        case ($urandom_range(0, 3))
            0:       ins[31:25] = 7'h00;
            1:       ins[31:25] = 7'h20;
            2:       ins[31:25] = 7'h01;
            default: ins[31:25] = ins[31:25];
        endcase
        return ins;
    endfunction

    initial begin
        n_checks = 0; n_pass = 0; checking_on = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
        bus.in_pc = '0; bus.out_ready = 1'b0;
        step();
        checking_on = 1;
        step();
        rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // addi x5,x6,10: one-cycle latency, pinned fields
        bus.out_ready = 1'b1;
        offer(32'h00A30293, 32'h0000_0100);
        chk("addi_valid",   {63'd0, bus.out_valid}, 64'd1);
        chk("addi_imm_sel", {61'd0, bus.out_ctrl.imm_sel}, 64'd0);
        chk("addi_src_b",   {63'd0, bus.out_ctrl.src_b_sel}, 64'd1);
        chk("addi_alu_set", {63'd0, bus.out_ctrl.alu_set}, 64'd0);
        chk("addi_regd",    {62'd0, bus.out_ctrl.regd_sel}, 64'd1);
        chk("addi_regw",    {63'd0, bus.out_ctrl.reg_write}, 64'd1);
        drain();

        // Three back-to-back under a two-cycle stall
        bus.out_ready = 1'b0;
        offer(32'h00100093, 32'h200);
        offer(32'h00208113, 32'h204);
        chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b1; bus.in_instr = 32'h00310193; bus.in_pc = 32'h208;
        step(); step();
        chk("stall_head_pc", {32'd0, bus.out_pc}, 64'h200);
        bus.out_ready = 1'b1;
        step(); step();
        bus.in_valid = 1'b0;
        drain();

        // mul in both configurations
        offer(32'h02B50533, 32'h300);
        chk("mul_muldiv",  {63'd0, bus.out_ctrl.muldiv}, 64'd1);
        chk("mul_op",      {61'd0, bus.out_ctrl.muldiv_op}, 64'd0);
        chk("mul_illegal", {63'd0, bus.out_ctrl.illegal}, 64'd0);
        chk("mul0_illegal", {63'd0, bus0.out_ctrl.illegal}, 64'd1);
        chk("mul0_system",  {63'd0, bus0.out_ctrl.system}, 64'd1);
        chk("mul0_regw",    {63'd0, bus0.out_ctrl.reg_write}, 64'd0);

        // bne then reserved branch funct3
        offer(32'h00B51463, 32'h304);
        chk("bne_branch", {63'd0, bus.out_ctrl.branch}, 64'd1);
        chk("bne_neg",    {63'd0, bus.out_ctrl.branch_neg}, 64'd1);
        chk("bne_alu_op", {61'd0, bus.out_ctrl.alu_op}, 64'd1);
        chk("bne_imm",    {61'd0, bus.out_ctrl.imm_sel}, 64'd5);
        offer(32'h0000A063, 32'h308);
        chk("bad_br_illegal", {63'd0, bus.out_ctrl.illegal}, 64'd1);
        drain();

        // Flush with both entries held, then flush during an accept
        bus.out_ready = 1'b0;
        offer(32'h00500293, 32'h400);
        offer(32'h00600313, 32'h404);
        bus.flush = 1'b1;
        offer(32'h00700393, 32'h408);
        bus.flush = 1'b0;
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_ready", {63'd0, bus.in_ready}, 64'd1);
        offer(32'h00800413, 32'h40C);
        bus.flush = 1'b1;
        offer(32'h00900493, 32'h410);
        bus.flush = 1'b0;
        chk("flush_drop_valid", {63'd0, bus.out_valid}, 64'd0);
        drain();

        // Reset while stalled with skid full
        bus.out_ready = 1'b0;
        offer(32'h00A00513, 32'h500);
        offer(32'h00B00593, 32'h504);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("midrst_ctrl",  {38'd0, bus.out_ctrl}, 64'd0);

        // Randomised traffic with backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_instr  = rand_instr();
            bus.in_pc     = $urandom & 32'hFFFF_FFFC;
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 99) < 3);
            step();
        end
        bus.flush = 1'b0;
        drain();

        checking_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
